// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans the 4x4 CHIP-8 hex keypad and synchronises the row senses.
// It debounces every key independently, using one sample per full scan.
// It presents the debounced key map, a combinational skip-query port, and a one-deep
// press-event buffer for the blocking "wait for key" instruction.
//
// Press-event handshake (valid/ack):
//   key_valid=1 means key_code holds an unconsumed press. key_code does not change while
//   key_valid=1, except on an edge where key_ack=1 and a new press arrives. On that edge the
//   new press replaces the consumed one and key_valid stays 1.
//   key_ack is honoured only while key_valid=1. key_ack with no new press clears key_valid
//   on that edge.
//   A press that arrives while key_valid=1 and key_ack=0 is dropped.
//   Releases never generate events.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic [15:0] keys,
  input  logic [3:0]  query_key,
  output logic        query_down,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ack
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  // Counter value at which one more disagreeing sample completes the debounce.
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);

  // Matrix position (row*4 + col) to CHIP-8 key code, following the keypad silkscreen.
  function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hC;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hD;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hB;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Scan position and synchroniser state.
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       col_nxt;
  logic [3:0]       sync_q1;
  logic [3:0]       sync_q2;
  logic             sample_en;

  // Per-key debounce counters, indexed by CHIP-8 code.
  logic [DEB_W-1:0] deb_cnt [16];
  logic [DEB_W-1:0] deb_nxt [16];
  logic [15:0]      keys_nxt;

  // Row decode for the column currently being driven.
  logic [3:0]       row_code [4];
  logic [3:0]       row_raw;

  // Press detected on this edge (lowest row wins when several rise together).
  logic             press_hit;
  logic [3:0]       press_code;

  assign col_nxt    = col_idx + 2'd1;
  assign sample_en  = (slot_cnt == SLOT_LAST);
  assign row_raw    = ~sync_q2;
  assign query_down = keys[query_key];

  // Slot counter and column drive; the column advances when the slot counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      col_out  <= 4'b1110;
    end else if (sample_en) begin
      slot_cnt <= '0;
      col_idx  <= col_nxt;
      col_out  <= ~(4'b0001 << col_nxt);
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous row senses (idle high, pulled up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 4'b1111;
      sync_q2 <= 4'b1111;
    end else begin
      sync_q1 <= row_in;
      sync_q2 <= sync_q1;
    end
  end

  // Map each row of the active column to its CHIP-8 code.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_code[r] = pos_to_code({2'(r), col_idx});
    end
  end

  // Debounce next state for the four keys of the active column; others hold.
  always_comb begin
    keys_nxt   = keys;
    press_hit  = 1'b0;
    press_code = 4'h0;
    for (int k = 0; k < 16; k++) begin
      deb_nxt[k] = deb_cnt[k];
    end
    if (sample_en) begin
      for (int r = 0; r < 4; r++) begin
        if (row_raw[r] == keys[row_code[r]]) begin
          // Sample agrees with the debounced state: any partial change is abandoned.
          deb_nxt[row_code[r]] = '0;
        end else if (deb_cnt[row_code[r]] == DEB_LAST) begin
          // Enough consecutive disagreeing samples: accept the new level.
          deb_nxt[row_code[r]]  = '0;
          keys_nxt[row_code[r]] = row_raw[r];
          if (row_raw[r] && !press_hit) begin
            press_hit  = 1'b1;
            press_code = row_code[r];
          end
        end else begin
          deb_nxt[row_code[r]] = deb_cnt[row_code[r]] + 1'b1;
        end
      end
    end
  end

  // Debounced key map and per-key counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys <= 16'h0000;
      for (int k = 0; k < 16; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      keys <= keys_nxt;
      for (int k = 0; k < 16; k++) begin
        deb_cnt[k] <= deb_nxt[k];
      end
    end
  end

  // One-deep press-event buffer with valid/ack handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else if (press_hit && (!key_valid || key_ack)) begin
      key_valid <= 1'b1;
      key_code  <= press_code;
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=8 and DEBOUNCE=3.
// With these values one full scan takes 32 cycles.
// A behavioural matrix model pulls a row low when a held key sits in the driven column.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 3;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] keys;
  logic [3:0]  query_key;
  logic        query_down;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;

  // Matrix positions currently held down (bit p = row*4 + col).
  logic [15:0] held;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_out    (col_out),
    .row_in     (row_in),
    .keys       (keys),
    .query_key  (query_key),
    .query_down (query_down),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ack    (key_ack)
  );

  // Clock.
  always #5 clk = ~clk;

  // Diode-free matrix: a held key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("col_one_low", 16'($countones(~col_out)), 16'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for key_valid to rise, counting cycles; bounded.
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!key_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    check("wait_valid", 16'(key_valid), 16'd1);
  endtask

  // Return right after the edge on which col_out switches to the target pattern.
  task automatic wait_col_start(input logic [3:0] target);
    logic [3:0] prev;
    logic       found;
    prev  = col_out;
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN && !found; i++) begin
      tick();
      if (col_out == target && prev != target) found = 1'b1;
      prev = col_out;
    end
    check("col_align", 16'(found), 16'd1);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  initial begin
    held      = 16'h0000;
    key_ack   = 1'b0;
    query_key = 4'h0;

    // Asynchronous reset, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_col_out", 16'(col_out), 16'h000E);
    check("rst_keys", keys, 16'h0000);
    check("rst_valid", 16'(key_valid), 16'd0);
    check("rst_code", 16'(key_code), 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Column 0 is driven for 8 cycles, then column 1.
    run(7);
    check("scan_col0_hold", 16'(col_out), 16'h000E);
    tick();
    check("scan_col1", 16'(col_out), 16'h000D);

    // 1. Hold p=5 from the start of column 1.
    //    Samples fall on edges 8, 40 and 72, so key 5 sets on edge 72.
    held[5] = 1'b1;
    wait_valid(4 * SCAN, cyc);
    check("t1_latency", 16'(cyc), 16'd72);
    check("t1_keys", keys, 16'h0020);
    check("t1_code", 16'(key_code), 16'h5);
    query_key = 4'h5;
    #1 check("t1_query5", 16'(query_down), 16'd1);
    query_key = 4'h4;
    #1 check("t1_query4", 16'(query_down), 16'd0);
    held = 16'h0000;
    ack_pulse();
    check("t1_ack_clears", 16'(key_valid), 16'd0);
    run(4 * SCAN);
    check("t1_release_keys", keys, 16'h0000);
    check("t1_release_no_event", 16'(key_valid), 16'd0);

    // 2. Bounce p=0 for at most 2 samples, then release.
    held[0] = 1'b1;
    run(60);
    held[0] = 1'b0;
    run(2 * SCAN);
    check("t2_bounce_keys", keys, 16'h0000);
    check("t2_bounce_valid", 16'(key_valid), 16'd0);
    held[0] = 1'b1;
    wait_valid(4 * SCAN, cyc);
    check("t2_keys", keys, 16'h0002);
    check("t2_code", 16'(key_code), 16'h1);

    // 3. Press A with no ack, then key 0: the new press is dropped.
    held = 16'h0000;
    ack_pulse();
    check("t3_ack_clears", 16'(key_valid), 16'd0);
    run(4 * SCAN);
    check("t3_idle_keys", keys, 16'h0000);
    held[12] = 1'b1;
    wait_valid(4 * SCAN, cyc);
    check("t3_code_a", 16'(key_code), 16'hA);
    held[13] = 1'b1;
    run(4 * SCAN);
    check("t3_keys", keys, 16'h0401);
    check("t3_valid_held", 16'(key_valid), 16'd1);
    check("t3_code_kept", 16'(key_code), 16'hA);
    ack_pulse();
    check("t3_ack_clears2", 16'(key_valid), 16'd0);
    run(2 * SCAN);
    check("t3_no_late_event", 16'(key_valid), 16'd0);

    // 4. Ack on the exact edge that F (p=15, column 3) debounces.
    held = 16'h0000;
    run(4 * SCAN);
    check("t4_idle_keys", keys, 16'h0000);
    held[1] = 1'b1;
    wait_valid(4 * SCAN, cyc);
    check("t4_code_2", 16'(key_code), 16'h2);
    wait_col_start(4'b0111);
    held[15] = 1'b1;
    // From column 3 slot 0, 71 cycles reach column 3 slot 7 of the third pass.
    run(71);
    check("t4_f_not_yet", 16'(keys[15]), 16'd0);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    check("t4_f_set", 16'(keys[15]), 16'd1);
    check("t4_valid_stays", 16'(key_valid), 16'd1);
    check("t4_code_f", 16'(key_code), 16'hF);
    tick();
    check("t4_valid_no_ack", 16'(key_valid), 16'd1);
    ack_pulse();
    check("t4_ack_clears", 16'(key_valid), 16'd0);

    // 5. Keys 1 and 4 pressed together in column 0: the lowest row wins.
    held = 16'h0000;
    run(4 * SCAN);
    check("t5_idle_keys", keys, 16'h0000);
    check("t5_idle_valid", 16'(key_valid), 16'd0);
    held[0] = 1'b1;
    held[4] = 1'b1;
    wait_valid(4 * SCAN, cyc);
    check("t5_keys", keys, 16'h0012);
    check("t5_code", 16'(key_code), 16'h1);
    run(2 * SCAN);
    check("t5_code_kept", 16'(key_code), 16'h1);
    ack_pulse();
    check("t5_ack_clears", 16'(key_valid), 16'd0);
    run(2 * SCAN);
    check("t5_single_event", 16'(key_valid), 16'd0);

    // 6. Reset during the debounce of key 9 (p=10, column 2) and in the middle of a slot.
    held = 16'h0000;
    run(4 * SCAN);
    wait_col_start(4'b1011);
    held[10] = 1'b1;
    run(43);
    check("t6_pre_keys", keys, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_col", 16'(col_out), 16'h000E);
    check("t6_rst_keys", keys, 16'h0000);
    check("t6_rst_valid", 16'(key_valid), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Fresh samples of column 2 fall on edges 24, 56 and 88 after the release.
    run(86);
    check("t6_two_scans", keys, 16'h0000);
    run(4);
    check("t6_keys", keys, 16'h0200);
    check("t6_valid", 16'(key_valid), 16'd1);
    check("t6_code", 16'(key_code), 16'h9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
